weight_update_engine: RTL and testbench
=======================================

Name: weight_update_engine

Overview:
- Sequential, parametrised successor to the combinational single-weight updater.
- Holds a bank of DEPTH unsigned weights and applies signed delta updates through a 2-stage pipeline with a valid/ready request handshake.
- Applies a learning-rate right-shift to each delta.
- Provides a bulk-clear state machine and a registered read-back port.
- Sits between the gradient/error calculator and the classifier's weight memory in the drowsiness-detector training path.

Parameters:
- WIDTH, 10, weight and delta bit width (unsigned).
- DEPTH, 16, number of weights in the bank (need not be a power of two).
- IDX_W, $clog2(DEPTH), index width.
- INIT_W, 512, value loaded into every weight at reset and on clear.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  update request valid
- req_ready  out  1  engine can accept a request this cycle
- req_idx  in  IDX_W  weight index to update
- req_delta  in  WIDTH  unsigned delta magnitude
- req_sign  in  1  1 = subtract delta, 0 = add delta
- lr_shift  in  3  learning-rate shift; delta_eff = req_delta >> lr_shift, sampled at acceptance
- clr_start  in  1  pulse: reset all weights to INIT_W
- busy  out  1  high while clearing
- out_valid  out  1  one-cycle pulse: update result available
- out_idx  out  IDX_W  index of completed update
- out_weight  out  WIDTH  new weight value
- out_err  out  1  one-cycle pulse with out_valid when index was out of range
- rd_idx  in  IDX_W  read-back index
- rd_data  out  WIDTH  bank[rd_idx], registered (1-cycle latency)

Behaviour:
- Reset (rst_n low, asynchronous):
  - All bank entries = INIT_W; state = IDLE.
  - req_ready = 0, busy = 0, out_valid = 0, out_err = 0, out_idx = 0, out_weight = 0, rd_data = 0.
- States:
  - IDLE: req_ready = !clr_start.
  - CLEAR: req_ready = 0, busy = 1.
  - Clear beats request: if clr_start and req_valid are high in the same IDLE cycle, the request is not accepted.
- Handshake:
  - Accept on req_valid && req_ready at edge T.
  - Stage 1 registers idx, delta_eff, sign.
  - Stage 2 reads bank[idx], computes the result, writes the bank and drives out_* at edge T+1.
  - out_valid is high for the cycle following edge T+1 (latency 2 edges).
  - Full throughput: one accepted request per cycle.
- Back-to-back updates to the same index: the second request reads the already-written value (write at T+1 precedes its stage-2 read). No stale data and no stall.
- Arithmetic (WIDTH+1-bit intermediate):
  - sign = 0: weight + delta_eff.
  - sign = 1: weight - delta_eff.
  - Overflow/underflow handling: see Optional Feature.
  - lr_shift >= WIDTH gives delta_eff = 0, so the weight is unchanged but out_valid still pulses.
- Out-of-range index (req_idx >= DEPTH):
  - Request is accepted; no bank write.
  - out_valid = 1, out_err = 1, out_weight = 0, out_idx = req_idx.
- Clear:
  - clr_start sampled in IDLE → CLEAR.
  - A counter writes INIT_W to entries 0..DEPTH-1, one per cycle (DEPTH cycles), then returns to IDLE.
  - A request already in stage 1 completes normally and out_valid still pulses.
  - clr_start during CLEAR is ignored.
- Read port:
  - rd_data <= bank[rd_idx] every cycle.
  - If rd_idx is written on the same edge, the pre-write value is returned.
  - rd_idx >= DEPTH returns 0.
- Reset mid-operation: pipeline and clear are aborted immediately and every bank entry returns to INIT_W.

Optional Feature:
- Macro WU_SATURATE_EN.
- Defined:
  - Sum > 2^WIDTH-1 clamps to 2^WIDTH-1.
  - Difference < 0 clamps to 0.
- Undefined: result wraps modulo 2^WIDTH, matching legacy single-weight updater behaviour.
- out_err is not affected in either case.

Test Plan:
- Default parameters, after reset read all 16 indices → rd_data = 512 each. Then idx 3, delta 50, sign 1, lr_shift 0, bank[3] = 860 → out_weight 810, out_idx 3, out_valid exactly 2 edges after accept.
- Weight 624 at idx 5, delta 205, sign 0, lr_shift 0 → 829. Same with lr_shift 2 (delta_eff 51) → 675.
- Overflow: weight 1000 + delta 100 → 1023 with WU_SATURATE_EN, 76 without. Underflow: weight 30 - delta 50 → 0 with macro, 1004 without.
- Three consecutive requests to idx 7 (512): +10, +10, -5, on consecutive cycles, req_valid held → out_weight 522, 532, 527 on consecutive cycles, no stall.
- Request idx 20 with DEPTH = 18 → out_valid and out_err pulse, out_weight 0, no bank entry changes.
- clr_start with req_valid high in the same cycle → request not accepted, busy high exactly 16 cycles, req_ready low throughout, all entries 512 afterwards. Assert rst_n mid-clear → outputs zero immediately, bank = 512.

Source files
------------

// File: rtl/weight_update_engine.sv
// Weight bank with a 2-stage signed-delta update pipeline, bulk clear FSM and registered read-back.
// Optional WU_SATURATE_EN: clamp results to [0, 2^WIDTH-1] instead of wrapping.
module weight_update_engine #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int INIT_W = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [WIDTH-1:0] req_delta,
  input  logic             req_sign,
  input  logic [2:0]       lr_shift,
  input  logic             clr_start,
  output logic             busy,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_weight,
  output logic             out_err,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [IDX_W:0]   DEPTH_W  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [WIDTH-1:0] INIT_V   = WIDTH'(INIT_W);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] clr_cnt_q;
  logic             rdy_q, busy_q;

  logic             s1_valid_q, s1_sign_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic [WIDTH-1:0] s1_delta_q;

  logic             out_valid_q, out_err_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [WIDTH-1:0] out_weight_q, rd_data_q;

  logic [WIDTH-1:0] bank_q [DEPTH];

  logic             accept, in_range, upd_wr, clr_wr, rd_in_range;
  logic [WIDTH-1:0] cur_w, result_d;

  // Clear wins over a simultaneous request, so readiness is gated by clr_start directly.
  assign req_ready = rdy_q & ~clr_start;
  assign busy      = busy_q;
  assign accept    = req_valid & req_ready;
  assign clr_wr    = (state_q == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt_q == LAST_IDX) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            rdy_q     <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_idx_q   <= '0;
      s1_delta_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_idx_q   <= req_idx;
        s1_delta_q <= req_delta >> lr_shift;
        s1_sign_q  <= req_sign;
      end
    end
  end

  assign in_range = ({1'b0, s1_idx_q} < DEPTH_W);
  assign upd_wr   = s1_valid_q & in_range;
  assign cur_w    = in_range ? bank_q[s1_idx_q] : '0;

`ifdef WU_SATURATE_EN
  logic [WIDTH:0] raw_d;
  always_comb begin
    raw_d    = s1_sign_q ? ({1'b0, cur_w} - {1'b0, s1_delta_q})
                         : ({1'b0, cur_w} + {1'b0, s1_delta_q});
    result_d = raw_d[WIDTH-1:0];
    if (raw_d[WIDTH]) result_d = s1_sign_q ? '0 : '1;
  end
`else
  assign result_d = s1_sign_q ? (cur_w - s1_delta_q) : (cur_w + s1_delta_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_idx_q    <= '0;
      out_weight_q <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      out_err_q   <= s1_valid_q & ~in_range;
      if (s1_valid_q) begin
        out_idx_q    <= s1_idx_q;
        out_weight_q <= in_range ? result_d : '0;
      end
    end
  end

  // Stage-2 write and clear write never target the same cycle: a request is never accepted
  // on the cycle clear starts, so any in-flight update lands before the first clear write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= INIT_V;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_wr && clr_cnt_q == IDX_W'(i))
          bank_q[i] <= INIT_V;
        else if (upd_wr && s1_idx_q == IDX_W'(i))
          bank_q[i] <= result_d;
      end
    end
  end

  assign rd_in_range = ({1'b0, rd_idx} < DEPTH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_in_range ? bank_q[rd_idx] : '0;
  end

  assign out_valid  = out_valid_q;
  assign out_err    = out_err_q;
  assign out_idx    = out_idx_q;
  assign out_weight = out_weight_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_weight_update_engine.sv
// Directed bench for weight_update_engine: default bank plus an 18-entry instance for range errors.
module tb_weight_update_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default instance (DEPTH 16, IDX_W 4)
  logic       req_valid = 0, req_sign = 0, clr_start = 0;
  logic [3:0] req_idx = 0, rd_idx = 0, out_idx;
  logic [9:0] req_delta = 0, out_weight, rd_data;
  logic [2:0] lr_shift = 0;
  logic       req_ready, busy, out_valid, out_err;

  weight_update_engine u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .req_delta(req_delta), .req_sign(req_sign), .lr_shift(lr_shift),
    .clr_start(clr_start), .busy(busy),
    .out_valid(out_valid), .out_idx(out_idx), .out_weight(out_weight), .out_err(out_err),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  // DEPTH 18 instance (IDX_W 5) for out-of-range indices
  logic       b_req_valid = 0;
  logic [4:0] b_req_idx = 0, b_rd_idx = 0, b_out_idx;
  logic [9:0] b_req_delta = 0, b_out_weight, b_rd_data;
  logic       b_req_ready, b_busy, b_out_valid, b_out_err;

  weight_update_engine #(.DEPTH(18)) u_dut18 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_idx(b_req_idx),
    .req_delta(b_req_delta), .req_sign(1'b0), .lr_shift(3'd0),
    .clr_start(1'b0), .busy(b_busy),
    .out_valid(b_out_valid), .out_idx(b_out_idx), .out_weight(b_out_weight), .out_err(b_out_err),
    .rd_idx(b_rd_idx), .rd_data(b_rd_data)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic upd(input int idx, input int d, input bit s, input int sh, input int exp_w);
    @(negedge clk);
    chk("req_ready", int'(req_ready), 1);
    req_valid = 1; req_idx = 4'(idx); req_delta = 10'(d); req_sign = s; lr_shift = 3'(sh);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    chk("out_valid_early", int'(out_valid), 0);
    @(negedge clk);
    chk("out_valid", int'(out_valid), 1);
    chk("out_err", int'(out_err), 0);
    chk("out_idx", int'(out_idx), idx);
    chk("out_weight", int'(out_weight), exp_w);
    $display("[TB] upd idx=%0d delta=%0d sign=%0d shift=%0d -> weight=%0d (exp %0d)",
             idx, d, s, sh, out_weight, exp_w);
  endtask

  task automatic rd(input int idx, input int exp);
    @(negedge clk);
    rd_idx = 4'(idx);
    @(negedge clk);
    chk("rd_data", int'(rd_data), exp);
  endtask

  task automatic rd_all(input int exp);
    for (int i = 0; i < 16; i++) rd(i, exp);
    $display("[TB] read-back of all 16 entries against %0d", exp);
  endtask

  int busy_cnt;
  int bad_ready;
  int stray_valid;

  initial begin
    // Reset state
    #12;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_out_weight", int'(out_weight), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst_n = 1;
    rd_all(512);

    // idx 3 to 860, then subtract 50
    upd(3, 348, 0, 0, 860);
    upd(3, 50, 1, 0, 810);
    rd(3, 810);

    // idx 5: 624 + 205, back to 624, then + (205>>2)
    upd(5, 112, 0, 0, 624);
    upd(5, 205, 0, 0, 829);
    upd(5, 205, 1, 0, 624);
    upd(5, 205, 0, 2, 675);
    upd(5, 1000, 0, 7, 682);  // 1000>>7 = 7

    // Overflow and underflow
    upd(0, 488, 0, 0, 1000);
`ifdef WU_SATURATE_EN
    upd(0, 100, 0, 0, 1023);
`else
    upd(0, 100, 0, 0, 76);
`endif
    upd(1, 482, 1, 0, 30);
`ifdef WU_SATURATE_EN
    upd(1, 50, 1, 0, 0);
`else
    upd(1, 50, 1, 0, 1004);
`endif

    // Back-to-back to idx 7: +10, +10, -5
    @(negedge clk);
    req_valid = 1; req_idx = 4'd7; req_delta = 10'd10; req_sign = 0; lr_shift = 0;
    @(negedge clk);
    chk("b2b_ready", int'(req_ready), 1);
    chk("b2b_early", int'(out_valid), 0);
    @(negedge clk);
    chk("b2b_ready", int'(req_ready), 1);
    chk("b2b_valid1", int'(out_valid), 1);
    chk("b2b_w1", int'(out_weight), 522);
    req_sign = 1; req_delta = 10'd5;
    @(negedge clk);
    req_valid = 0;
    chk("b2b_valid2", int'(out_valid), 1);
    chk("b2b_w2", int'(out_weight), 532);
    @(negedge clk);
    chk("b2b_valid3", int'(out_valid), 1);
    chk("b2b_w3", int'(out_weight), 527);
    @(negedge clk);
    chk("b2b_idle", int'(out_valid), 0);
    $display("[TB] back-to-back idx 7 sequence done");
    rd(7, 527);

    // Same-edge read returns pre-write value
    @(negedge clk);
    rd_idx = 4'd7;
    req_valid = 1; req_idx = 4'd7; req_delta = 10'd3; req_sign = 0;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("rd_prewrite", int'(rd_data), 527);
    @(negedge clk);
    chk("rd_postwrite", int'(rd_data), 530);

    // Out-of-range index on the 18-entry instance
    @(negedge clk);
    b_req_valid = 1; b_req_idx = 5'd20; b_req_delta = 10'd9;
    @(negedge clk);
    b_req_valid = 0;
    chk("oor_early", int'(b_out_valid), 0);
    @(negedge clk);
    chk("oor_valid", int'(b_out_valid), 1);
    chk("oor_err", int'(b_out_err), 1);
    chk("oor_weight", int'(b_out_weight), 0);
    chk("oor_idx", int'(b_out_idx), 20);
    @(negedge clk);
    chk("oor_err_pulse", int'(b_out_err), 0);
    for (int i = 0; i < 18; i++) begin
      b_rd_idx = 5'(i);
      @(negedge clk);
      chk("oor_bank", int'(b_rd_data), 512);
    end
    b_rd_idx = 5'd20;
    @(negedge clk);
    chk("oor_rd_zero", int'(b_rd_data), 0);
    $display("[TB] out-of-range request idx=20 on DEPTH=18 done");

    // Clear with a simultaneous request; extra clr_start mid-clear is ignored
    @(negedge clk);
    clr_start = 1; req_valid = 1; req_idx = 4'd2; req_delta = 10'd100; req_sign = 0;
    #1;
    chk("clr_ready_gated", int'(req_ready), 0);
    @(negedge clk);
    clr_start = 0; req_valid = 0;
    busy_cnt = 0; bad_ready = 0; stray_valid = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy) busy_cnt++;
      if (busy && req_ready) bad_ready++;
      if (out_valid) stray_valid++;
      clr_start = (i == 5);
      @(negedge clk);
      clr_start = 0;
    end
    chk("clr_busy_cycles", busy_cnt, 16);
    chk("clr_ready_low", bad_ready, 0);
    chk("clr_req_dropped", stray_valid, 0);
    chk("clr_ready_after", int'(req_ready), 1);
    $display("[TB] clear: busy for %0d cycles", busy_cnt);
    rd_all(512);

    // Reset mid-clear
    upd(3, 100, 0, 0, 612);
    @(negedge clk);
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(req_ready), 0);
    chk("mid_rst_rd", int'(rd_data), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    rd_all(512);
    $display("[TB] reset during clear done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
